// File: rtl/fruit_video_pkg.sv
// Shared types and constants for the fruit ninja video path.
//
// Contents:
//   H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL : VGA timing constants
//   sprite_entry_t : one sprite table entry {x, y, id, valid}
//   slot_t         : one per-line slot {x, id, row, valid}
//   scan_state_t   : per-line scan FSM states
//   spr_addr()     : sprite ROM address from (id, row, col)
package fruit_video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] id;
        logic       valid;
    } sprite_entry_t;

    // Row and column are 5 bits wide, which fixes sprites at 32x32.
    typedef struct packed {
        logic [9:0] x;
        logic [2:0] id;
        logic [4:0] row;
        logic       valid;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } scan_state_t;

    // id*W*H + row*W + col. With W = H = 32 every term lands in its own
    // bit field, so the sum is a plain concatenation.
    function automatic logic [12:0] spr_addr(input logic [2:0] id,
                                             input logic [4:0] row,
                                             input logic [4:0] col);
        return {id, row, col};
    endfunction

endpackage

// File: rtl/fruit_slot_match.sv
// Combinational priority match of the current pixel column against the
// per-line slot list. The lowest slot index wins, which is also the lowest
// sprite table index because slots are filled in table order.
//
// Ports:
//   draw_x : current pixel column
//   slots  : draw slot list for this line
//   hit    : some valid slot covers draw_x
//   id     : image index of the winning slot
//   row    : sprite row of the winning slot
//   col    : draw_x minus the winning slot's left column
module fruit_slot_match
    import fruit_video_pkg::*;
#(
    parameter int SLOTS    = 4,
    parameter int SPRITE_W = 32
) (
    input  logic [9:0]             draw_x,
    input  slot_t [SLOTS-1:0]      slots,
    output logic                   hit,
    output logic [2:0]             id,
    output logic [4:0]             row,
    output logic [4:0]             col
);

    always_comb begin
        hit = 1'b0;
        id  = '0;
        row = '0;
        col = '0;
        // Walk from the highest slot down so the lowest covering slot is
        // the last one written.
        for (int s = SLOTS - 1; s >= 0; s--) begin
            // 11-bit compare so a sprite near column 1023 never wraps.
            if (slots[s].valid &&
                (draw_x >= slots[s].x) &&
                ({1'b0, draw_x} < ({1'b0, slots[s].x} + 11'(SPRITE_W)))) begin
                hit = 1'b1;
                id  = slots[s].id;
                row = slots[s].row;
                // Difference is below 32 here, so the low bits suffice.
                col = draw_x[4:0] - slots[s].x[4:0];
            end
        end
    end

endmodule

// File: rtl/fruit_sprite_scheduler.sv
// Per-scanline sprite scheduler. During horizontal blank it scans the
// frame-latched sprite table and picks up to SLOTS sprites covering the next
// line; during active video it produces the background and sprite ROM
// addresses plus a layer select, all registered with one cycle of latency.
//
// Ports:
//   vga_clk       : pixel clock
//   Reset         : synchronous, active-high reset
//   DrawX, DrawY  : current pixel column / line from the VGA counters
//   blank         : 1 = active video
//   tbl_we        : write strobe into the shadow sprite table
//   tbl_idx       : shadow entry index
//   tbl_x, tbl_y  : sprite left column / top line
//   tbl_id        : sprite image index
//   tbl_valid     : entry enabled
//   bg_address    : background ROM address, DrawY*640 + DrawX
//   spr_address   : sprite ROM address, id*W*H + row*W + col
//   layer_sel     : 1 = sprite pixel, 0 = background
//   line_overflow : sticky per frame, some line had more than SLOTS hits
//   busy          : scan FSM not IDLE
module fruit_sprite_scheduler
    import fruit_video_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        tbl_we,
    input  logic [2:0]  tbl_idx,
    input  logic [9:0]  tbl_x,
    input  logic [9:0]  tbl_y,
    input  logic [2:0]  tbl_id,
    input  logic        tbl_valid,
    output logic [18:0] bg_address,
    output logic [12:0] spr_address,
    output logic        layer_sel,
    output logic        line_overflow,
    output logic        busy
);

    localparam int IDX_W  = $clog2(NUM_SPRITES);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CNT_W  = $clog2(SLOTS + 1);

    sprite_entry_t      shadow_tbl [NUM_SPRITES];
    sprite_entry_t      active_tbl [NUM_SPRITES];
    slot_t [SLOTS-1:0]  build_list;
    slot_t [SLOTS-1:0]  draw_list;
    scan_state_t        state;
    logic [IDX_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   build_cnt;

    // Start of vertical blank: the one cycle where the shadow table is
    // latched into the active table and the overflow flag is rearmed.
    logic copy_cycle;
    assign copy_cycle = (DrawX == 10'(H_ACTIVE)) && (DrawY == 10'(V_ACTIVE));

    // ---------------------------------------------------------------
    // Sprite tables
    // ---------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            // The copy reads the pre-write shadow, so a write landing in the
            // copy cycle only shows up after the following vblank.
            if (copy_cycle) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
            if (tbl_we) begin
                shadow_tbl[tbl_idx] <= '{x: tbl_x, y: tbl_y, id: tbl_id, valid: tbl_valid};
            end
        end
    end

    // ---------------------------------------------------------------
    // Scan: one table entry per cycle against the next line
    // ---------------------------------------------------------------
    logic [9:0]    next_y;
    sprite_entry_t cur;
    logic          entry_hit;
    logic          ovf_set;
    slot_t         new_slot;

    assign next_y = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign cur    = active_tbl[scan_idx];

    // 11-bit compare: a sprite at the bottom of the table range never wraps
    // around to cover line 0.
    assign entry_hit = cur.valid &&
                       ({1'b0, next_y} >= {1'b0, cur.y}) &&
                       ({1'b0, next_y} <  ({1'b0, cur.y} + 11'(SPRITE_H)));

    assign ovf_set = (state == SCAN) && entry_hit && (build_cnt == CNT_W'(SLOTS));

    always_comb begin
        new_slot       = '0;
        new_slot.x     = cur.x;
        new_slot.id    = cur.id;
        new_slot.row   = next_y[4:0] - cur.y[4:0];
        new_slot.valid = 1'b1;
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state         <= IDLE;
            scan_idx      <= '0;
            build_cnt     <= '0;
            build_list    <= '0;
            draw_list     <= '0;
            line_overflow <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DrawX == 10'(H_ACTIVE)) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        scan_idx   <= '0;
                        build_cnt  <= '0;
                        build_list <= '0;
                    end
                end
                SCAN: begin
                    // Hits past the last slot are dropped; ovf_set flags them.
                    if (entry_hit && (build_cnt < CNT_W'(SLOTS))) begin
                        build_list[build_cnt[SLOT_W-1:0]] <= new_slot;
                        build_cnt <= build_cnt + CNT_W'(1);
                    end
                    if (scan_idx == IDX_W'(NUM_SPRITES - 1)) begin
                        state <= WAIT;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                WAIT: begin
                    // The swap lines up with the last pixel of the line, so
                    // the new list is in place for pixel 0 of the next line.
                    if (DrawX == 10'(H_TOTAL - 1)) begin
                        draw_list <= build_list;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A set in the copy cycle takes priority over the frame clear.
            if (ovf_set) begin
                line_overflow <= 1'b1;
            end else if (copy_cycle) begin
                line_overflow <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Pixel path
    // ---------------------------------------------------------------
    logic        pix_hit;
    logic [2:0]  pix_id;
    logic [4:0]  pix_row;
    logic [4:0]  pix_col;
    logic [18:0] bg_next;

    fruit_slot_match #(
        .SLOTS    (SLOTS),
        .SPRITE_W (SPRITE_W)
    ) u_slot_match (
        .draw_x (DrawX),
        .slots  (draw_list),
        .hit    (pix_hit),
        .id     (pix_id),
        .row    (pix_row),
        .col    (pix_col)
    );

    // DrawY*640 = DrawY*512 + DrawY*128.
    assign bg_next = {DrawY, 9'b0} + {2'b0, DrawY, 7'b0} + {9'b0, DrawX};

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            bg_address  <= '0;
            spr_address <= '0;
            layer_sel   <= 1'b0;
        end else begin
            bg_address  <= bg_next;
            spr_address <= pix_hit ? spr_addr(pix_id, pix_row, pix_col) : 13'd0;
            // Addresses keep tracking in blank; only the layer is gated.
            layer_sel   <= pix_hit && blank;
        end
    end

endmodule

// File: tb/tb_fruit_sprite_scheduler.sv
// Directed bench for fruit_sprite_scheduler. The bench drives DrawX/DrawY
// line by line (lines are visited out of order to keep the run short) and
// predicts every registered output from a behavioural model of the tables,
// the per-line schedule and the overflow flag.
module tb_fruit_sprite_scheduler;

    logic        vga_clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        tbl_we;
    logic [2:0]  tbl_idx;
    logic [9:0]  tbl_x;
    logic [9:0]  tbl_y;
    logic [2:0]  tbl_id;
    logic        tbl_valid;
    logic [18:0] bg_address;
    logic [12:0] spr_address;
    logic        layer_sel;
    logic        line_overflow;
    logic        busy;

    fruit_sprite_scheduler dut (
        .vga_clk       (vga_clk),
        .Reset         (Reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .blank         (blank),
        .tbl_we        (tbl_we),
        .tbl_idx       (tbl_idx),
        .tbl_x         (tbl_x),
        .tbl_y         (tbl_y),
        .tbl_id        (tbl_id),
        .tbl_valid     (tbl_valid),
        .bg_address    (bg_address),
        .spr_address   (spr_address),
        .layer_sel     (layer_sel),
        .line_overflow (line_overflow),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ---------------- scoreboard ----------------
    // Word layout: {busy, line_overflow, layer_sel, spr_address, bg_address}
    localparam int W = 35;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int phase  = 0;
    int pend_x = -1;

    // ---------------- reference model ----------------
    int m_sh_x[8], m_sh_y[8], m_sh_id[8];
    bit m_sh_v[8];
    int m_ac_x[8], m_ac_y[8], m_ac_id[8];
    bit m_ac_v[8];
    int m_dr_x[4], m_dr_id[4], m_dr_row[4];
    int m_dr_n;
    int m_bd_x[4], m_bd_id[4], m_bd_row[4];
    int m_bd_n;
    bit m_ovf;
    bit m_live;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_id[i] = 0; m_sh_v[i] = 0;
            m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_id[i] = 0; m_ac_v[i] = 0;
        end
        m_dr_n = 0;
        m_bd_n = 0;
        m_ovf  = 0;
        m_live = 0;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pixel clock: drive, predict, clock, compare.
    task automatic step(input int x, input int y, input bit rst, input bit we);
        logic [W-1:0] exp_w;
        logic [W-1:0] got;
        bit hit;
        int spr;
        int ny;
        int k;
        Reset  = rst;
        DrawX  = 10'(x);
        DrawY  = 10'(y);
        blank  = (x < 640) && (y < 480);
        tbl_we = we;
        if (rst) begin
            model_reset();
            exp_w = '0;
        end else begin
            hit = 0;
            spr = 0;
            for (int s = 0; s < m_dr_n; s++) begin
                if (!hit && x >= m_dr_x[s] && x < m_dr_x[s] + 32) begin
                    hit = 1;
                    spr = m_dr_id[s] * 1024 + m_dr_row[s] * 32 + (x - m_dr_x[s]);
                end
            end
            if (x == 640 && y == 480) begin
                for (int i = 0; i < 8; i++) begin
                    m_ac_x[i] = m_sh_x[i]; m_ac_y[i] = m_sh_y[i];
                    m_ac_id[i] = m_sh_id[i]; m_ac_v[i] = m_sh_v[i];
                end
                m_ovf = 0;
            end
            if (we) begin
                m_sh_x[tbl_idx]  = int'(tbl_x);
                m_sh_y[tbl_idx]  = int'(tbl_y);
                m_sh_id[tbl_idx] = int'(tbl_id);
                m_sh_v[tbl_idx]  = tbl_valid;
            end
            ny = (y == 524) ? 0 : y + 1;
            if (x == 640) begin
                m_live = 1;
                m_bd_n = 0;
            end else if (m_live && x >= 641 && x <= 648) begin
                k = x - 641;
                if (m_ac_v[k] && ny >= m_ac_y[k] && ny < m_ac_y[k] + 32) begin
                    if (m_bd_n < 4) begin
                        m_bd_x[m_bd_n]   = m_ac_x[k];
                        m_bd_id[m_bd_n]  = m_ac_id[k];
                        m_bd_row[m_bd_n] = ny - m_ac_y[k];
                        m_bd_n++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (m_live && x == 799) begin
                for (int s = 0; s < 4; s++) begin
                    m_dr_x[s] = m_bd_x[s]; m_dr_id[s] = m_bd_id[s]; m_dr_row[s] = m_bd_row[s];
                end
                m_dr_n = m_bd_n;
                m_live = 0;
            end
            exp_w = {m_live, m_ovf, hit && (x < 640) && (y < 480), 13'(spr), 19'(y * 640 + x)};
        end
        exp_q.push_back(exp_w);
        @(posedge vga_clk);
        #1;
        got   = {busy, line_overflow, layer_sel, spr_address, bg_address};
        exp_w = exp_q.pop_front();
        chk($sformatf("pix_y%0d_x%0d", y, x), got, exp_w);
        Reset  = 1'b0;
        tbl_we = 1'b0;

        // Spot values taken straight from the expected behaviour.
        if (phase == 1 && y == 2 && x == 5)
            chk("bg_y2_x5", 35'(bg_address), 35'd1285);
        if (phase == 2 && y == 50 && x == 100)
            chk("l50_x100", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd2048}));
        if (phase == 2 && y == 50 && x == 131)
            chk("l50_x131", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd2079}));
        if (phase == 2 && y == 50 && x == 132)
            chk("l50_x132_layer", 35'(layer_sel), 35'd0);
        if (phase == 2 && (y == 49 || y == 82) && x == 110)
            chk($sformatf("l%0d_layer", y), 35'(layer_sel), 35'd0);
        if (phase == 3 && y == 100 && x == 215)
            chk("overlap_x215", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd5135}));
        if (phase == 3 && y == 100 && x == 235)
            chk("entry3_x235", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd7193}));
        if (phase == 4 && y == 10 && x == 160)
            chk("ovf_l10_x160", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd3082}));
        if (phase == 4 && y == 10 && x == 305)
            chk("ovf_entry4_absent", 35'(layer_sel), 35'd0);
        if (phase == 5 && (y == 10 || y == 300) && x == 5)
            chk($sformatf("move_l%0d_x5", y), 35'({layer_sel, spr_address}), 35'({1'b1, 13'd5}));
        if (phase == 5 && y == 100 && x == 625)
            chk("late_write_absent", 35'(layer_sel), 35'd0);
        if (phase == 6 && y == 100 && x == 625)
            chk("late_write_present", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd6149}));
        if (phase == 6 && y == 100 && x == 645)
            chk("clip_blank_layer", 35'(layer_sel), 35'd0);
        if (phase == 7 && y == 100 && x == 625)
            chk("post_reset_bg_only", 35'(layer_sel), 35'd0);
        if (phase == 7 && y == 150 && x == 300)
            chk("resume_l150", 35'({layer_sel, spr_address}), 35'({1'b1, 13'd1024}));
    endtask

    // One full line. Reset is held over [rlo, rhi]; a pending table write
    // fires at pend_x.
    task automatic run_line(input int y, input int rlo = -1, input int rhi = -1);
        for (int x = 0; x < 800; x++) begin
            step(x, y, (x >= rlo) && (x <= rhi), x == pend_x);
        end
    endtask

    task automatic write_entry(input int idx, input int x, input int y, input int id, input bit v);
        tbl_idx   = 3'(idx);
        tbl_x     = 10'(x);
        tbl_y     = 10'(y);
        tbl_id    = 3'(id);
        tbl_valid = v;
        step(0, 0, 1'b0, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; tbl_we = 1'b0;
        tbl_idx = '0; tbl_x = '0; tbl_y = '0; tbl_id = '0; tbl_valid = 1'b0;
        model_reset();

        // Reset with counters running, then an empty-table line.
        phase = 1;
        run_line(1, 0, 9);
        run_line(2);

        // Single sprite at (100, 50), image 2.
        phase = 2;
        write_entry(0, 100, 50, 2, 1'b1);
        run_line(480);
        run_line(49);
        run_line(50);
        run_line(81);
        run_line(82);

        // Overlapping entries 1 and 3 on line 100.
        phase = 3;
        write_entry(1, 200, 100, 5, 1'b1);
        write_entry(3, 210, 100, 7, 1'b1);
        run_line(480);
        run_line(99);
        run_line(100);

        // Five hits on line 10.
        phase = 4;
        write_entry(0,   0, 10, 0, 1'b1);
        write_entry(1,  50, 10, 1, 1'b1);
        write_entry(2, 100, 10, 2, 1'b1);
        write_entry(3, 150, 10, 3, 1'b1);
        write_entry(4, 300, 10, 4, 1'b1);
        run_line(480);
        run_line(9);
        chk("ovf_set", 35'(line_overflow), 35'd1);
        run_line(10);
        run_line(200);
        chk("ovf_held", 35'(line_overflow), 35'd1);
        run_line(480);
        chk("ovf_cleared", 35'(line_overflow), 35'd0);

        // Mid-frame move of entry 0, then a write coincident with the copy.
        phase = 5;
        write_entry(0, 0, 300, 0, 1'b1);
        run_line(9);
        run_line(10);
        tbl_idx = 3'd5; tbl_x = 10'd620; tbl_y = 10'd100; tbl_id = 3'd6; tbl_valid = 1'b1;
        pend_x = 640;
        run_line(480);
        pend_x = -1;
        run_line(299);
        run_line(300);
        run_line(99);
        run_line(100);

        // One frame later the late write is live, clipped at the right edge.
        phase = 6;
        run_line(480);
        run_line(99);
        run_line(100);

        // Reset in the middle of the scan.
        phase = 7;
        run_line(99, 645, 645);
        run_line(100);
        run_line(101);
        write_entry(0, 300, 150, 1, 1'b1);
        run_line(480);
        run_line(149);
        run_line(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fruit_sprite_scheduler.md
Name: fruit_sprite_scheduler

Overview:
- Per-scanline sprite scheduler for the fruit ninja video path.
- Sits between the VGA timing counters (DrawX/DrawY) and the background ROM/palette lookup.
- During each horizontal blank it scans a frame-latched sprite table and selects up to SLOTS sprites that cover the next line.
- During active video it generates, each pixel, either the background ROM address or the sprite ROM address, plus a layer select.
- Transparency and palette muxing happen downstream.

Parameters:
- NUM_SPRITES, 8, sprite table entries (power of 2).
- SLOTS, 4, max sprites drawn per scanline.
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2).
- H_ACTIVE, 640, active pixels per line.
- H_TOTAL, 800, pixels per line including blank.
- V_TOTAL, 525, lines per frame.
- V_ACTIVE, 480, active lines.

Ports:
- vga_clk  in  1  pixel clock; sole clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column (0..H_TOTAL-1).
- DrawY  in  10  current line (0..V_TOTAL-1).
- blank  in  1  1 = active video.
- tbl_we  in  1  write strobe, shadow sprite table.
- tbl_idx  in  3  entry index.
- tbl_x  in  10  sprite left column.
- tbl_y  in  10  sprite top line.
- tbl_id  in  3  sprite image index.
- tbl_valid  in  1  entry enabled.
- bg_address  out  19  background ROM address.
- spr_address  out  13  sprite ROM address: id*W*H + row*W + col.
- layer_sel  out  1  1 = sprite pixel, 0 = background.
- line_overflow  out  1  sticky per frame: some line had more than SLOTS hits.
- busy  out  1  scan FSM not IDLE.

Behaviour:
- Reset:
  - All outputs 0.
  - Shadow table, active table and both slot lists cleared (all entries invalid).
  - FSM in IDLE.
- Table writes:
  - tbl_we writes the shadow table in one cycle, at any time.
  - Shadow is copied to the active table in the single cycle where DrawX==H_ACTIVE and DrawY==V_ACTIVE (start of vblank).
  - A write in that same cycle lands in the shadow and takes effect next frame.
- Scan target line: ny = DrawY+1, wrapping to 0 when DrawY==V_TOTAL-1.
- FSM states IDLE, SCAN, WAIT:
  - IDLE -> SCAN when DrawX==H_ACTIVE. Clear the build slot list and the index counter.
  - SCAN: one entry per cycle, index 0..NUM_SPRITES-1.
  - An entry hits if valid && ny>=y && ny<y+SPRITE_H. Compare in 11 bits, no wrap.
  - Hits are appended in index order: store x, id, row = ny-y (5 bits).
  - A hit with the build list already full sets line_overflow and is dropped.
  - After the last index -> WAIT.
  - WAIT -> IDLE at DrawX==H_TOTAL-1. The build list swaps into the draw list in that same cycle.
  - Scan finishes in NUM_SPRITES cycles, well inside the 160-cycle hblank.
- line_overflow clears at the active-table copy cycle; a set in that same cycle wins.
- Pixel path:
  - Slot s covers DrawX if valid && DrawX>=x && DrawX<x+SPRITE_W.
  - Lowest slot index wins; that is the lowest table index.
  - col = DrawX-x.
  - bg_address = DrawY*640+DrawX, computed with shifts and adds (DrawY<<9 + DrawY<<7 + DrawX), no divider.
  - bg_address, spr_address and layer_sel are all registered: 1-cycle latency from DrawX/DrawY, matching the ROM's registered read.
- When blank==0, layer_sel is forced to 0; addresses keep updating.
- Sprites with x > H_ACTIVE-SPRITE_W are clipped at the right edge; no wrap.
- Reset mid-scan returns to IDLE. The draw list is empty until the next swap, so that line shows background only.

Decomposition:
- Package fruit_video_pkg holds:
  - H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL.
  - sprite_entry_t typedef {x, y, id, valid}.
  - slot_t typedef {x, id, row, valid}.
  - spr_addr function (id,row,col).
- One sub-module, fruit_slot_match: combinational priority hit/column select over SLOTS entries, instantiated once in the pixel path.

Test Plan:
- Reset with the timing counters running -> all outputs 0. A line with an empty table gives layer_sel=0 everywhere and bg_address=DrawY*640+DrawX one cycle later (DrawY=2, DrawX=5 -> 1285).
- Entry 0 {x=100, y=50, id=2, valid}, committed at vblank.
  - Line 50, DrawX=100 -> layer_sel=1, spr_address=2048.
  - DrawX=131 -> 2079.
  - DrawX=132 -> layer_sel=0.
  - Lines 49 and 82 -> layer_sel=0.
- Entries 1 and 3 overlapping at x=200, same y -> entry 1's id wins; its spr_address appears on overlap pixels.
- Five valid entries on line 10 -> entries 0-3 drawn, entry 4 absent, line_overflow=1. It stays set through the frame and clears at the next vblank copy.
- Table write mid-frame moving entry 0 to y=300 -> no change until after the next vblank copy. A write coincident with the copy cycle appears one frame later.
- Reset asserted during SCAN (DrawX=645) -> busy=0 next cycle; the next line is background only; normal scheduling resumes the line after.
